// File: rtl/mult_operand_sequencer.sv
// Operand/result sequencer around a combinational N-bit multiplier: captures an
// operand pair, waits SETTLE cycles for the product to ripple, then holds it until acked.
module mult_operand_sequencer #(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_s,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] result,
  output logic           flag_zero,
  output logic           flag_ovf,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [2*N-1:0] result_q, result_d;
  logic           flag_zero_q, flag_zero_d;
  logic           flag_ovf_q, flag_ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      result_q    <= '0;
      flag_zero_q <= 1'b0;
      flag_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      result_q    <= result_d;
      flag_zero_q <= flag_zero_d;
      flag_ovf_q  <= flag_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    result_d    = result_q;
    flag_zero_d = flag_zero_q;
    flag_ovf_d  = flag_ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mul_a_d = op_a;
          mul_b_d = op_b;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // mul_s is only trusted on the last settle cycle; earlier values may still be rippling
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d    = mul_s;
          flag_zero_d = (mul_s == '0);
          flag_ovf_d  = (mul_s[2*N-1:N] != '0);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result    = result_q;
  assign flag_zero = flag_zero_q;
  assign flag_ovf  = flag_ovf_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer (N=4, SETTLE=2) with a behavioural
// multiplier on mul_s and a queue of expected products.
module tb_mult_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [3:0] op_a = '0;
  logic [3:0] op_b = '0;
  logic       in_ready, res_valid, flag_zero, flag_ovf, busy;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_s, result;
  logic       glitch = 1'b0;

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference multiplier; glitch forces garbage to show early samples are ignored
  assign mul_s = glitch ? 8'hFF : ({4'b0, mul_a} * {4'b0, mul_b});

  mult_operand_sequencer #(.N(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .flag_zero(flag_zero), .flag_ovf(flag_ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle handshake; returns at the negedge after the accept edge
  task automatic accept(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    chk("pre_accept_in_ready", 16'(in_ready), 16'd1);
    in_valid = 1'b1; op_a = a; op_b = b;
    p = 8'(a) * 8'(b);
    exp_q.push_back(p);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul_a_captured", 16'(mul_a), 16'(a));
    chk("mul_b_captured", 16'(mul_b), 16'(b));
    chk("busy_after_accept", 16'(busy), 16'd1);
    $display("accept a=%0d b=%0d expect=%02h", a, b, p);
  endtask

  task automatic wait_result(input int lat);
    int n = 0;
    logic [7:0] e;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("result_latency", 16'(n), 16'(lat));
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      chk("result", 16'(result), 16'(e));
      chk("flag_zero", 16'(flag_zero), 16'(e == 8'h00));
      chk("flag_ovf", 16'(flag_ovf), 16'(e[7:4] != 4'h0));
      $display("result=%02h expected=%02h zero=%0b ovf=%0b", result, e, flag_zero, flag_ovf);
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_after_ack", 16'(res_valid), 16'd0);
    chk("in_ready_after_ack", 16'(in_ready), 16'd1);
  endtask

  initial begin
    // 1: reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_res_valid", 16'(res_valid), 16'd0);
    chk("rst_result", 16'(result), 16'h00);
    chk("rst_mul_a", 16'(mul_a), 16'd0);
    chk("rst_mul_b", 16'(mul_b), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 16'(in_ready), 16'd1);
    chk("idle_busy", 16'(busy), 16'd0);

    // 2: single op
    accept(4'd10, 4'd11);
    wait_result(2);
    ack();

    // 3: back-to-back ops, immediate ack
    accept(4'd15, 4'd15); wait_result(2); ack();
    accept(4'd3, 4'd2);   wait_result(2); ack();
    accept(4'd0, 4'd9);   wait_result(2); ack();

    // 4: consumer stalls while new operands are offered
    accept(4'd10, 4'd11);
    wait_result(2);
    in_valid = 1'b1; op_a = 4'd7; op_b = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_result", 16'(result), 16'h6E);
      chk("stall_in_ready", 16'(in_ready), 16'd0);
      chk("stall_res_valid", 16'(res_valid), 16'd1);
    end
    in_valid = 1'b0;
    chk("stall_mul_a_kept", 16'(mul_a), 16'd10);
    ack();
    chk("mul_a_kept_in_idle", 16'(mul_a), 16'd10);
    accept(4'd7, 4'd7); wait_result(2); ack();

    // 5: reset during first settle cycle aborts
    in_valid = 1'b1; op_a = 4'd5; op_b = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy_before", 16'(busy), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_res_valid", 16'(res_valid), 16'd0);
      chk("abort_busy", 16'(busy), 16'd0);
      @(negedge clk);
    end
    chk("abort_result", 16'(result), 16'h00);
    $display("abort 5*5 by reset: res_valid=%0b result=%02h", res_valid, result);
    accept(4'd2, 4'd3); wait_result(2); ack();

    // 6: op_a changes during settle; mul_s glitches before the capture cycle
    accept(4'd4, 4'd4);
    op_a = 4'd9;
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    chk("mul_a_stable", 16'(mul_a), 16'd4);
    wait_result(1);
    ack();

    // 7: res_ready held high throughout -> one-cycle hold
    res_ready = 1'b1;
    accept(4'd12, 4'd1);
    wait_result(2);
    @(negedge clk);
    chk("one_cycle_hold", 16'(res_valid), 16'd0);
    res_ready = 1'b0;
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
